// File: rtl/multi_clk_en_gen_pkg.sv
// Shared constants and elaboration-time helpers for the clock-enable generator.
package multi_clk_en_gen_pkg;

   localparam int unsigned ACC_WIDTH_DEF = 32;
   localparam int unsigned CH_IDX_W      = 3;
   localparam int unsigned MAX_CHANNELS  = 8;

   // Increment giving f_out = f_clk * num / den for the default accumulator width.
   function automatic logic [ACC_WIDTH_DEF-1:0] incr_from_ratio(input longint unsigned num,
                                                                input longint unsigned den);
      longint unsigned tmp;
      tmp = (num << ACC_WIDTH_DEF) / den;
      return tmp[ACC_WIDTH_DEF-1:0];
   endfunction

endpackage

// File: rtl/multi_clk_en_gen_if.sv
// Configuration bus: write handshake, commit strobe and error feedback.
interface multi_clk_en_gen_if
   import multi_clk_en_gen_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CH_IDX_W-1:0]  cfg_channel;
   logic [ACC_WIDTH-1:0] cfg_incr;
   logic [ACC_WIDTH-1:0] cfg_phase;
   logic                 cfg_commit;
   logic                 cfg_err;

   modport master (
      output cfg_valid, cfg_channel, cfg_incr, cfg_phase, cfg_commit,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_channel, cfg_incr, cfg_phase, cfg_commit,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/multi_clk_en_gen_nco_channel.sv
// One fractional phase accumulator channel with pending/active rate registers.
module multi_clk_en_gen_nco_channel
   import multi_clk_en_gen_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run_i,
   input  logic                 wr_i,
   input  logic                 commit_i,
   input  logic [ACC_WIDTH-1:0] wr_incr_i,
   input  logic [ACC_WIDTH-1:0] wr_phase_i,
   output logic                 en_next_o,
   output logic                 clk_en_o,
   output logic                 clk_level_o
);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] incr_q, incr_d;
   logic [ACC_WIDTH-1:0] pend_incr_q, pend_incr_d;
   logic [ACC_WIDTH-1:0] pend_phase_q, pend_phase_d;
   logic                 en_q, en_d;
   logic                 level_q, level_d;
   logic [ACC_WIDTH:0]   sum;

   // Next-state: pending write, commit load (write-through) or accumulator step.
   always_comb begin
      pend_incr_d  = pend_incr_q;
      pend_phase_d = pend_phase_q;
      incr_d       = incr_q;
      acc_d        = acc_q;
      en_d         = 1'b0;
      sum          = {1'b0, acc_q} + {1'b0, incr_q};
      if (wr_i) begin
         pend_incr_d  = wr_incr_i;
         pend_phase_d = wr_phase_i;
      end
      if (commit_i) begin
         incr_d = pend_incr_d;
         acc_d  = pend_phase_d;
      end else if (run_i) begin
         acc_d = sum[ACC_WIDTH-1:0];
         en_d  = sum[ACC_WIDTH];
      end
      // level tracks the MSB of the accumulator value being registered
      level_d = acc_d[ACC_WIDTH-1];
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q        <= '0;
         incr_q       <= '0;
         pend_incr_q  <= '0;
         pend_phase_q <= '0;
         en_q         <= 1'b0;
         level_q      <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         incr_q       <= incr_d;
         pend_incr_q  <= pend_incr_d;
         pend_phase_q <= pend_phase_d;
         en_q         <= en_d;
         level_q      <= level_d;
      end
   end

   assign en_next_o   = en_d;
   assign clk_en_o    = en_q;
   assign clk_level_o = level_q;

endmodule

// File: rtl/multi_clk_en_gen.sv
// Multi-channel clock-enable generator: config decode, commit control, lock detection.
module multi_clk_en_gen
   import multi_clk_en_gen_pkg::*;
#(
   parameter int unsigned CHANNELS   = 3,
   parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int unsigned LOCK_TICKS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   multi_clk_en_gen_if.slave   cfg,
   output logic [CHANNELS-1:0] clk_en,
   output logic [CHANNELS-1:0] clk_level,
   output logic                locked
);

   localparam int unsigned LCW = $clog2(LOCK_TICKS + 1);

   logic                cfg_ready_q, cfg_ready_d;
   logic                cfg_err_q, cfg_err_d;
   logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
   logic                locked_q, locked_d;
   logic                accept;
   logic                in_range;
   logic [CHANNELS-1:0] en_next;

   assign accept   = cfg.cfg_valid & cfg_ready_q;
   assign in_range = 32'(cfg.cfg_channel) < CHANNELS;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic wr;
      assign wr = accept & in_range & (cfg.cfg_channel == CH_IDX_W'(i));

      multi_clk_en_gen_nco_channel #(
         .ACC_WIDTH (ACC_WIDTH)
      ) u_nco (
         .clk         (clk),
         .reset       (reset),
         .run_i       (run),
         .wr_i        (wr),
         .commit_i    (cfg.cfg_commit),
         .wr_incr_i   (cfg.cfg_incr),
         .wr_phase_i  (cfg.cfg_phase),
         .en_next_o   (en_next[i]),
         .clk_en_o    (clk_en[i]),
         .clk_level_o (clk_level[i])
      );
   end

   // Handshake, error flag and channel-0 lock counter next-state.
   always_comb begin
      cfg_ready_d = ~cfg.cfg_commit;
      cfg_err_d   = accept & ~in_range;
      lock_cnt_d  = lock_cnt_q;
      locked_d    = locked_q;
      if (cfg.cfg_commit) begin
         lock_cnt_d = '0;
         locked_d   = 1'b0;
      end else if (en_next[0] && (lock_cnt_q < LCW'(LOCK_TICKS))) begin
         // counting the upcoming strobe lets locked rise together with it
         lock_cnt_d = lock_cnt_q + LCW'(1);
         if (lock_cnt_d == LCW'(LOCK_TICKS)) locked_d = 1'b1;
      end
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_ready_q <= 1'b1;
         cfg_err_q   <= 1'b0;
         lock_cnt_q  <= '0;
         locked_q    <= 1'b0;
      end else begin
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
         lock_cnt_q  <= lock_cnt_d;
         locked_q    <= locked_d;
      end
   end

   assign cfg.cfg_ready = cfg_ready_q;
   assign cfg.cfg_err   = cfg_err_q;
   assign locked        = locked_q;

endmodule

// File: tb/tb_multi_clk_en_gen.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs into a queue.
module tb_multi_clk_en_gen;
   import multi_clk_en_gen_pkg::*;

   typedef struct packed {
      logic [2:0] en;
      logic [2:0] lvl;
      logic       locked;
      logic       ready;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [2:0] clk_en;
   logic [2:0] clk_level;
   logic       locked;

   multi_clk_en_gen_if #(.ACC_WIDTH(32)) cfg_if ();

   multi_clk_en_gen #(
      .CHANNELS   (3),
      .ACC_WIDTH  (32),
      .LOCK_TICKS (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .cfg       (cfg_if),
      .clk_en    (clk_en),
      .clk_level (clk_level),
      .locked    (locked)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   // model state
   logic [31:0] m_acc[3], m_inc[3], m_pinc[3], m_pph[3];
   logic [2:0]  m_en, m_lvl;
   int          m_cnt;
   logic        m_locked, m_ready, m_err;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = '0; m_inc[i] = '0; m_pinc[i] = '0; m_pph[i] = '0;
      end
      m_en = '0; m_lvl = '0; m_cnt = 0; m_locked = 1'b0; m_ready = 1'b1; m_err = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      logic            acc_ok, inr;
      longint unsigned s;
      if (reset) begin
         model_reset();
         return;
      end
      acc_ok = cfg_if.cfg_valid && m_ready;
      inr    = cfg_if.cfg_channel < 3'd3;
      for (int i = 0; i < 3; i++) begin
         if (acc_ok && inr && (int'(cfg_if.cfg_channel) == i)) begin
            m_pinc[i] = cfg_if.cfg_incr;
            m_pph[i]  = cfg_if.cfg_phase;
         end
         m_en[i] = 1'b0;
         if (cfg_if.cfg_commit) begin
            m_inc[i] = m_pinc[i];
            m_acc[i] = m_pph[i];
         end else if (run) begin
            s = longint'(m_acc[i]) + longint'(m_inc[i]);
            m_en[i]  = (s >= 64'h1_0000_0000);
            m_acc[i] = 32'(s % 64'h1_0000_0000);
         end
         m_lvl[i] = m_acc[i] >= 32'h8000_0000;
      end
      if (cfg_if.cfg_commit) begin
         m_cnt = 0; m_locked = 1'b0;
      end else if (m_en[0] && m_cnt < 16) begin
         m_cnt++;
         if (m_cnt == 16) m_locked = 1'b1;
      end
      m_err   = acc_ok && !inr;
      m_ready = !cfg_if.cfg_commit;
   endtask

   // One clock: predict, push, advance, pop and compare.
   task automatic cycle();
      exp_t e;
      model_step();
      sb_q.push_back('{en: m_en, lvl: m_lvl, locked: m_locked, ready: m_ready, err: m_err});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("clk_en", 32'(clk_en), 32'(e.en));
      check_val("clk_level", 32'(clk_level), 32'(e.lvl));
      check_val("locked", 32'(locked), 32'(e.locked));
      check_val("cfg_ready", 32'(cfg_if.cfg_ready), 32'(e.ready));
      check_val("cfg_err", 32'(cfg_if.cfg_err), 32'(e.err));
   endtask

   task automatic idle();
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_commit = 1'b0;
   endtask

   task automatic write(input logic [2:0] ch, input logic [31:0] inc, input logic [31:0] ph,
                        input logic commit);
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_channel = ch;
      cfg_if.cfg_incr    = inc;
      cfg_if.cfg_phase   = ph;
      cfg_if.cfg_commit  = commit;
      cycle();
      idle();
   endtask

   task automatic commit();
      cfg_if.cfg_commit = 1'b1;
      cycle();
      idle();
   endtask

   initial begin
      int first0, first1, lockn, cnt0, cnt2, cnt_all;
      reset = 1'b1; run = 1'b0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_commit = 1'b0; cfg_if.cfg_channel = '0;
      cfg_if.cfg_incr = '0; cfg_if.cfg_phase = '0;
      model_reset();
      cycle(); cycle();
      check_val("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
      check_val("rst_en", 32'(clk_en), 32'd0);
      reset = 1'b0; run = 1'b1;

      // rates 1/4, 1/4 half-cycle offset, 1/3
      write(3'd0, incr_from_ratio(1, 4), 32'h0, 1'b0);
      write(3'd1, 32'h4000_0000, 32'h8000_0000, 1'b0);
      write(3'd2, 32'h5555_5555, 32'h0, 1'b0);
      commit();
      first0 = -1; first1 = -1; lockn = -1; cnt2 = 0;
      for (int n = 1; n <= 3000; n++) begin
         cycle();
         if (clk_en[0] && first0 < 0) first0 = n;
         if (clk_en[1] && first1 < 0) first1 = n;
         if (locked && lockn < 0) lockn = n;
         if (clk_en[2]) cnt2++;
      end
      check_val("first_en0", 32'(first0), 32'd4);
      check_val("first_en1", 32'(first1), 32'd2);
      check_val("lock_lat", 32'(lockn), 32'd64);
      check_val("ch2_count", 32'(cnt2), 32'd999);

      // pending write without commit leaves rate unchanged
      write(3'd0, 32'h2000_0000, 32'h0, 1'b0);
      cnt0 = 0;
      for (int n = 0; n < 40; n++) begin
         cycle();
         if (clk_en[0]) cnt0++;
      end
      check_val("no_commit_rate", 32'(cnt0), 32'd10);

      // write-through commit idles ch2 and applies ch0's new rate
      write(3'd2, 32'h0, 32'h0, 1'b1);
      check_val("lock_drop", 32'(locked), 32'd0);
      cnt0 = 0; cnt2 = 0; lockn = -1;
      for (int n = 1; n <= 1000; n++) begin
         cycle();
         if (clk_en[0]) cnt0++;
         if (clk_en[2]) cnt2++;
         if (locked && lockn < 0) lockn = n;
      end
      check_val("new_rate", 32'(cnt0), 32'd125);
      check_val("idle_ch2", 32'(cnt2), 32'd0);
      check_val("relock_lat", 32'(lockn), 32'd128);

      // out-of-range channel
      write(3'd5, 32'h1234_5678, 32'h1, 1'b0);
      check_val("err_pulse", 32'(cfg_if.cfg_err), 32'd1);
      cycle();
      check_val("err_clear", 32'(cfg_if.cfg_err), 32'd0);

      // freeze
      run = 1'b0;
      cnt_all = 0;
      for (int n = 0; n < 10; n++) begin
         cycle();
         if (clk_en != 3'b000) cnt_all++;
      end
      check_val("freeze_en", 32'(cnt_all), 32'd0);
      run = 1'b1;
      for (int n = 0; n < 40; n++) cycle();

      // reset discards pending writes
      write(3'd1, 32'h7000_0000, 32'h0, 1'b0);
      for (int n = 0; n < 5; n++) cycle();
      reset = 1'b1;
      cycle();
      check_val("rst_locked", 32'(locked), 32'd0);
      check_val("rst_level", 32'(clk_level), 32'd0);
      reset = 1'b0;
      commit();
      cnt_all = 0;
      for (int n = 0; n < 50; n++) begin
         cycle();
         if (clk_en != 3'b000) cnt_all++;
      end
      check_val("post_rst_idle", 32'(cnt_all), 32'd0);
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
